// File: rtl/snap_ram_arbiter.sv
// snap_ram_arbiter: shares the single system RAM port between the snapshot loader's
// write FIFO and the CPU. Define ARB_TIMEOUT_EN to enable the mem_ack watchdog.
module snap_ram_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 4,
    parameter int LD_BURST   = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              ovf,
    output logic              tmo
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BURST_W = $clog2(LD_BURST + 1);
    localparam int ENTRY_W = ADDR_W + 8;

    generate
        if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
            LD_BURST < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
            $error("snap_ram_arbiter: FIFO_DEPTH must be a power of two >= 4, LD_BURST >= 1, TIMEOUT 1..255");
        end
    endgenerate

    typedef enum logic {ST_IDLE, ST_MEM} state_t;
    typedef enum logic {OWN_LD, OWN_CPU} owner_t;

    state_t             state_reg;
    owner_t             owner_reg;
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic [BURST_W-1:0] burst_reg;
    logic               ovf_reg;
    logic               mem_req_reg;
    logic               mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [7:0]         mem_wdata_reg;
    logic               cpu_ack_reg;
    logic [7:0]         cpu_dout_reg;

    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic               cpu_pending;
    logic               ld_wins;
    logic               grant_any;
    logic               timeout_hit;
    logic [ADDR_W-1:0]  head_addr;
    logic [7:0]         head_data;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_reg;
    logic       tmo_reg;

    assign timeout_hit = (state_reg == ST_MEM) && !mem_ack &&
                         (tmo_cnt_reg == 8'(TIMEOUT - 1));

    // Counter sits at zero outside MEM, so every transaction starts from a fresh count.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tmo_cnt_reg <= '0;
            tmo_reg     <= 1'b0;
        end else if (state_reg != ST_MEM) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
            if (timeout_hit)
                tmo_reg <= 1'b1;
        end
    end

    assign tmo = tmo_reg;
`else
    assign timeout_hit = 1'b0;
    assign tmo         = 1'b0;
`endif

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign push       = ld_wr && !fifo_full;
    assign pop        = (state_reg == ST_MEM) && (owner_reg == OWN_LD) && (mem_ack || timeout_hit);
    // One spare slot absorbs a strobe the loader issued before seeing ld_ready fall.
    assign ld_ready   = (count_reg <= CNT_W'(FIFO_DEPTH - 2));
    assign {head_addr, head_data} = fifo_mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {ld_addr, ld_data};
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (ld_wr && fifo_full)
                ovf_reg <= 1'b1;
        end
    end

    // cpu_req is still high during the ack cycle; masking it stops a duplicate CPU grant.
    assign cpu_pending = cpu_req && !cpu_ack_reg;
    assign ld_wins     = !fifo_empty &&
                         (!cpu_pending ||
                          (count_reg >= CNT_W'(FIFO_DEPTH / 2) && burst_reg < BURST_W'(LD_BURST)));
    assign grant_any   = !fifo_empty || cpu_pending;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            burst_reg <= '0;
        end else if (!cpu_req) begin
            burst_reg <= '0;
        end else if (state_reg == ST_IDLE && grant_any && !ld_wins) begin
            burst_reg <= '0;
        end else if (pop && burst_reg != BURST_W'(LD_BURST)) begin
            burst_reg <= burst_reg + BURST_W'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= OWN_LD;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cpu_ack_reg   <= 1'b0;
            cpu_dout_reg  <= '0;
        end else begin
            cpu_ack_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_any) begin
                        state_reg   <= ST_MEM;
                        mem_req_reg <= 1'b1;
                        if (ld_wins) begin
                            owner_reg     <= OWN_LD;
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= head_addr;
                            mem_wdata_reg <= head_data;
                        end else begin
                            owner_reg     <= OWN_CPU;
                            mem_we_reg    <= cpu_we;
                            mem_addr_reg  <= cpu_addr;
                            mem_wdata_reg <= cpu_din;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        state_reg   <= ST_IDLE;
                        mem_req_reg <= 1'b0;
                        if (owner_reg == OWN_CPU) begin
                            cpu_ack_reg <= 1'b1;
                            if (!mem_we_reg)
                                cpu_dout_reg <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        state_reg   <= ST_IDLE;
                        mem_req_reg <= 1'b0;
                        if (owner_reg == OWN_CPU) begin
                            cpu_ack_reg  <= 1'b1;
                            cpu_dout_reg <= 8'hFF;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign cpu_ack   = cpu_ack_reg;
    assign cpu_dout  = cpu_dout_reg;
    assign ovf       = ovf_reg;
    assign busy      = !fifo_empty || (state_reg == ST_MEM && owner_reg == OWN_LD);

endmodule
